// File: rtl/seq_ratio_scaler.sv
// Sequential ratio scaler: out = in * num / den through a shared restoring divider,
// with selectable rounding, output saturation and divide-by-zero flagging.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for an operand, in_ready=1
//   MUL    | register |in|*num and the result sign, load divider count
//   DIV    | one restoring quotient bit per edge, MSB first, P edges
//   FIX    | rounding, sign restore, saturation / div0 forcing
//   DONE   | result held until out_ready, out_valid=1
module seq_ratio_scaler #(
    parameter int WIDTH  = 64,
    parameter int COEF_W = 8,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [COEF_W-1:0] num,
    input  logic [COEF_W-1:0] den,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_sat,
    output logic              out_div0
);

    localparam int P     = WIDTH + COEF_W;
    localparam int CNT_W = $clog2(P + 1);

    localparam logic [P:0]       LIM  = (P+1)'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]  in_q,       in_d;
    logic [COEF_W-1:0] num_q,      num_d;
    logic [COEF_W-1:0] den_q,      den_d;
    logic [P-1:0]      quo_q,      quo_d;
    logic [COEF_W-1:0] rem_q,      rem_d;
    logic              sign_q,     sign_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_sat_q,  out_sat_d;
    logic              out_div0_q, out_div0_d;

    logic [WIDTH-1:0]  abs_in;
    logic [COEF_W:0]   rem_sh;
    logic              take;
    logic [COEF_W:0]   rem_sub;
    logic              round_up;
    logic [P:0]        mag;
    logic              pos_ovf;
    logic              neg_ovf;
    logic              in_zero;
    logic [WIDTH-1:0]  res_data;
    logic              res_sat;
    logic              res_div0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_MUL;
            S_MUL:   state_d = S_DIV;
            S_DIV:   if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out_data  = out_data_q;
        out_sat   = out_sat_q;
        out_div0  = out_div0_q;
    end

    // Divider step and result shaping
    always_comb begin
        abs_in  = in_q[WIDTH-1] ? (WIDTH'(0) - in_q) : in_q;
        rem_sh  = {rem_q, quo_q[P-1]};
        take    = (rem_sh >= {1'b0, den_q});
        rem_sub = take ? (rem_sh - {1'b0, den_q}) : rem_sh;

        // rem < den after the last step, so 2*rem fits in COEF_W+1 bits
        round_up = (ROUND != 0) && ({rem_q, 1'b0} >= {1'b0, den_q});
        mag      = {1'b0, quo_q} + (P+1)'(round_up);
        pos_ovf  = (mag >= LIM);
        neg_ovf  = (mag > LIM);
        in_zero  = (in_q == '0);

        res_data = '0;
        res_sat  = 1'b0;
        res_div0 = 1'b0;
        if (den_q == '0) begin
            res_div0 = 1'b1;
            if (!in_zero) begin
                res_sat  = 1'b1;
                res_data = sign_q ? MINV : MAXV;
            end
        end else if (sign_q) begin
            if (neg_ovf) begin
                res_sat  = 1'b1;
                res_data = MINV;
            end else begin
                res_data = WIDTH'(0) - mag[WIDTH-1:0];
            end
        end else begin
            if (pos_ovf) begin
                res_sat  = 1'b1;
                res_data = MAXV;
            end else begin
                res_data = mag[WIDTH-1:0];
            end
        end
    end

    // Datapath next-state
    always_comb begin
        in_d       = in_q;
        num_d      = num_q;
        den_d      = den_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_div0_d = out_div0_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_d  = in_data;
                    num_d = num;
                    den_d = den;
                end
            end
            S_MUL: begin
                quo_d  = P'(abs_in) * P'(num_q);
                rem_d  = '0;
                sign_d = in_q[WIDTH-1];
                cnt_d  = CNT_W'(P);
            end
            S_DIV: begin
                quo_d = {quo_q[P-2:0], take};
                rem_d = rem_sub[COEF_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                out_data_d = res_data;
                out_sat_d  = res_sat;
                out_div0_d = res_div0;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_data_d = '0;
                    out_sat_d  = 1'b0;
                    out_div0_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q       <= '0;
            num_q      <= '0;
            den_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_div0_q <= 1'b0;
        end else begin
            in_q       <= in_d;
            num_q      <= num_d;
            den_q      <= den_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_div0_q <= out_div0_d;
        end
    end

endmodule

// File: tb/tb_seq_ratio_scaler.sv
// Bench for seq_ratio_scaler: truncating and rounding instances run in lockstep
// against an arithmetic reference model and hand-computed vectors.
module tb_seq_ratio_scaler;

    localparam int LAT = 74;
    localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;

    typedef struct {
        logic signed [63:0] d;
        logic               s;
        logic               z;
        int                 t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  num;
    logic [7:0]  den;
    logic        out_ready;

    logic [1:0]        ir, ov, os, oz;
    logic [1:0][63:0]  od;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t eq[2][$];

    seq_ratio_scaler #(.WIDTH(64), .COEF_W(8), .ROUND(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .num(num), .den(den), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_sat(os[0]), .out_div0(oz[0])
    );

    seq_ratio_scaler #(.WIDTH(64), .COEF_W(8), .ROUND(1)) u_round (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .num(num), .den(den), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_sat(os[1]), .out_div0(oz[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed product, Verilog-style truncating divide, optional
    // half-away rounding on the remainder, then clamp to the 64-bit range.
    function automatic exp_t model(input logic signed [63:0] x, input logic [7:0] n,
                                   input logic [7:0] d, input bit rnd);
        exp_t e;
        logic signed [95:0] xs, p, q, r, ar, dd, maxw, minw;
        e.t  = 0;
        e.z  = (d == 8'd0);
        e.s  = 1'b0;
        e.d  = '0;
        maxw = 96'sh7FFF_FFFF_FFFF_FFFF;
        minw = -maxw - 96'sd1;
        if (d == 8'd0) begin
            if (x > 0) begin
                e.d = MAXV; e.s = 1'b1;
            end else if (x < 0) begin
                e.d = MINV; e.s = 1'b1;
            end
        end else begin
            xs = x;
            dd = $signed({88'd0, d});
            p  = xs * $signed({88'd0, n});
            q  = p / dd;
            r  = p % dd;
            ar = (r < 0) ? -r : r;
            if (rnd && (2 * ar >= dd)) q = (p < 0) ? q - 96'sd1 : q + 96'sd1;
            if (q > maxw) begin
                e.d = MAXV; e.s = 1'b1;
            end else if (q < minw) begin
                e.d = MINV; e.s = 1'b1;
            end else begin
                e.d = q[63:0];
            end
        end
        return e;
    endfunction

    // Per-cycle compare against the model queues
    always @(negedge clk) begin
        if (!rst_n) begin
            eq[0].delete();
            eq[1].delete();
        end else begin
            bit accept;
            accept = in_valid && (eq[0].size() == 0);
            for (int k = 0; k < 2; k++) begin
                bit exp_v;
                exp_v = (eq[k].size() > 0) && (cyc >= eq[k][0].t);
                chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(eq[k].size() == 0));
                chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(exp_v));
                if (exp_v) begin
                    chk($sformatf("out_data%0d", k), od[k], eq[k][0].d);
                    chk($sformatf("out_sat%0d", k), 64'(os[k]), 64'(eq[k][0].s));
                    chk($sformatf("out_div0%0d", k), 64'(oz[k]), 64'(eq[k][0].z));
                    if (out_ready) void'(eq[k].pop_front());
                end
            end
            if (accept) begin
                for (int k = 0; k < 2; k++) begin
                    exp_t e;
                    e   = model(in_data, num, den, k[0]);
                    e.t = cyc + 1 + LAT;
                    eq[k].push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic signed [63:0] x, input logic [7:0] n,
                          input logic [7:0] d, input logic signed [63:0] e0,
                          input logic signed [63:0] e1, input logic es, input logic ez,
                          input int hold);
        exp_t m0, m1;
        int w;
        m0 = model(x, n, d, 1'b0);
        m1 = model(x, n, d, 1'b1);
        chk({name, "_model_trunc"}, m0.d, e0);
        chk({name, "_model_round"}, m1.d, e1);
        w = 0;
        while (!ir[0] && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) chk({name, "_idle_timeout"}, 64'd1, 64'd0);
        in_valid = 1'b1;
        in_data  = x;
        num      = n;
        den      = d;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!ov[0] && w < 200) begin
            in_valid = (w % 5 == 2);
            in_data  = {$urandom, $urandom};
            num      = 8'($urandom);
            den      = 8'($urandom);
            tick();
            w++;
        end
        in_valid = 1'b0;
        if (w >= 200) chk({name, "_valid_timeout"}, 64'd1, 64'd0);
        chk({name, "_data_trunc"}, od[0], e0);
        chk({name, "_data_round"}, od[1], e1);
        chk({name, "_sat"}, 64'(os[0]), 64'(es));
        chk({name, "_div0"}, 64'(oz[0]), 64'(ez));
        repeat (hold) tick();
        chk({name, "_held_data"}, od[0], e0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_released_valid"}, 64'(ov[0]), 64'd0);
        chk({name, "_released_ready"}, 64'(ir[0]), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        num       = '0;
        den       = '0;
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", 64'(ir[k]), 64'd1);
            chk("rst_out_valid", 64'(ov[k]), 64'd0);
            chk("rst_out_data", od[k], 64'd0);
            chk("rst_out_sat", 64'(os[k]), 64'd0);
            chk("rst_out_div0", 64'(oz[k]), 64'd0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_op("pos",      64'sd1000,  8'd90,  8'd100, 64'sd900,  64'sd900,  1'b0, 1'b0, 0);
        run_op("neg",     -64'sd1000,  8'd90,  8'd100, -64'sd900, -64'sd900, 1'b0, 1'b0, 0);
        run_op("rnd_pos",  64'sd15,    8'd9,   8'd10,  64'sd13,   64'sd14,   1'b0, 1'b0, 2);
        run_op("rnd_neg", -64'sd15,    8'd9,   8'd10,  -64'sd13,  -64'sd14,  1'b0, 1'b0, 0);
        run_op("half_pos", 64'sd5,     8'd1,   8'd2,   64'sd2,    64'sd3,    1'b0, 1'b0, 0);
        run_op("half_neg",-64'sd5,     8'd1,   8'd2,   -64'sd2,   -64'sd3,   1'b0, 1'b0, 0);
        run_op("sat_max",  MAXV,       8'd255, 8'd1,   MAXV,      MAXV,      1'b1, 1'b0, 10);
        run_op("sat_min",  MINV,       8'd2,   8'd1,   MINV,      MINV,      1'b1, 1'b0, 0);
        run_op("min_exact",MINV,       8'd1,   8'd1,   MINV,      MINV,      1'b0, 1'b0, 0);
        run_op("div0_pos", 64'sd5,     8'd7,   8'd0,   MAXV,      MAXV,      1'b1, 1'b1, 0);
        run_op("div0_neg",-64'sd5,     8'd7,   8'd0,   MINV,      MINV,      1'b1, 1'b1, 3);
        run_op("div0_zero",64'sd0,     8'd7,   8'd0,   64'sd0,    64'sd0,    1'b0, 1'b1, 0);
        run_op("num_zero", 64'sd12345, 8'd0,   8'd200, 64'sd0,    64'sd0,    1'b0, 1'b0, 0);
        run_op("big",      64'sd1_000_000_007, 8'd255, 8'd3, 64'sd85_000_000_595,
               64'sd85_000_000_595, 1'b0, 1'b0, 0);

        // Abort an operation in the middle of the divide
        in_valid = 1'b1;
        in_data  = 64'sd1000;
        num      = 8'd90;
        den      = 8'd100;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_out_valid", 64'(ov[k]), 64'd0);
            chk("abort_out_data", od[k], 64'd0);
            chk("abort_in_ready", 64'(ir[k]), 64'd1);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (LAT + 5) tick();
        chk("abort_no_result", 64'(ov[0]), 64'd0);
        run_op("after_rst", 64'sd100, 8'd90, 8'd100, 64'sd90, 64'sd90, 1'b0, 1'b0, 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
